// File: rtl/ats_eligibility_scheduler.sv
// rtl/ats_eligibility_scheduler.sv - ATS token-bucket eligibility scheduler for one shaped stream
// Accepts arrival time + length, computes eligibility, waits for local time, then emits pass/drop.
module ats_eligibility_scheduler #(
  parameter int TIMESTAMP_WIDTH    = 72,
  parameter int FRAME_LENGTH_WIDTH = 16,
  parameter int RATE_WIDTH         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TIMESTAMP_WIDTH-1:0]    s_axis_timestamp_tdata,
  input  logic                          s_axis_timestamp_tvalid,
  output logic                          s_axis_timestamp_tready,
  input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
  input  logic                          s_axis_frame_length_tvalid,
  output logic                          s_axis_frame_length_tready,
  input  logic [TIMESTAMP_WIDTH-1:0]    current_time,
  input  logic [RATE_WIDTH-1:0]         cfg_ticks_per_byte,
  input  logic [FRAME_LENGTH_WIDTH-1:0] cfg_burst_bytes,
  input  logic [TIMESTAMP_WIDTH-1:0]    cfg_max_residence,
  output logic                          m_axis_decision_tdata,
  output logic                          m_axis_decision_tvalid,
  input  logic                          m_axis_decision_tready,
  output logic [31:0]                   drop_count
);

  localparam int TS = TIMESTAMP_WIDTH;
  localparam int PW = FRAME_LENGTH_WIDTH + RATE_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_WAIT,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                          r_in_ready;
  logic                          r_dec_valid;
  logic                          r_pass;
  logic [31:0]                   r_drop_count;
  logic [TS-1:0]                 r_arr;
  logic [FRAME_LENGTH_WIDTH-1:0] r_len;
  logic [TS-1:0]                 r_len_rec;
  logic [TS-1:0]                 r_e2f;
  logic [TS-1:0]                 r_max_res;
  logic [TS-1:0]                 r_elig;
  logic [TS-1:0]                 r_bucket_empty_time;
  logic [TS-1:0]                 r_group_elig;

  logic          w_accept;
  logic [PW-1:0] w_len_prod;
  logic [PW-1:0] w_e2f_prod;
  logic [TS-1:0] w_sched;
  logic [TS-1:0] w_full;
  logic [TS-1:0] w_elig_ag;
  logic [TS-1:0] w_elig;
  logic [TS-1:0] w_limit;
  logic [TS-1:0] w_new_bucket;
  logic          w_pass;

  assign s_axis_timestamp_tready    = r_in_ready;
  assign s_axis_frame_length_tready = r_in_ready;
  assign m_axis_decision_tvalid     = r_dec_valid;
  assign m_axis_decision_tdata      = r_pass;
  assign drop_count                 = r_drop_count;

  // Both streams must present together; a lone tvalid is left unconsumed.
  assign w_accept = (r_state == S_IDLE) && r_in_ready &&
                    s_axis_timestamp_tvalid && s_axis_frame_length_tvalid;

  assign w_len_prod = PW'(r_len) * PW'(cfg_ticks_per_byte);
  assign w_e2f_prod = PW'(cfg_burst_bytes) * PW'(cfg_ticks_per_byte);

  assign w_sched   = r_bucket_empty_time + r_len_rec;
  assign w_full    = r_bucket_empty_time + r_e2f;
  assign w_elig_ag = (r_arr > r_group_elig) ? r_arr : r_group_elig;
  assign w_elig    = (w_elig_ag > w_sched) ? w_elig_ag : w_sched;
  assign w_limit   = r_arr + r_max_res;
  assign w_pass    = (w_elig <= w_limit);
  // Idle time beyond the full-bucket point is credit that cannot be banked.
  assign w_new_bucket = (w_elig < w_full) ? w_sched : (w_sched + (w_elig - w_full));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_LOAD;
      S_LOAD: w_next = S_CALC;
      S_CALC: w_next = S_WAIT;
      S_WAIT: if (!r_pass || (current_time >= r_elig)) w_next = S_OUT;
      S_OUT:  if (m_axis_decision_tready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready          <= 1'b0;
      r_dec_valid         <= 1'b0;
      r_pass              <= 1'b0;
      r_drop_count        <= '0;
      r_arr               <= '0;
      r_len               <= '0;
      r_len_rec           <= '0;
      r_e2f               <= '0;
      r_max_res           <= '0;
      r_elig              <= '0;
      r_bucket_empty_time <= '0;
      r_group_elig        <= '0;
    end else begin
      r_in_ready  <= (w_next == S_IDLE);
      r_dec_valid <= (w_next == S_OUT);

      if (w_accept) begin
        r_arr <= s_axis_timestamp_tdata;
        r_len <= s_axis_frame_length_tdata;
      end

      if (r_state == S_LOAD) begin
        r_len_rec <= TS'(w_len_prod);
        r_e2f     <= TS'(w_e2f_prod);
        r_max_res <= cfg_max_residence;
      end

      if (r_state == S_CALC) begin
        r_pass <= w_pass;
        r_elig <= w_elig;
        if (w_pass) begin
          r_group_elig        <= w_elig;
          r_bucket_empty_time <= w_new_bucket;
        end else if (r_drop_count != 32'hFFFF_FFFF) begin
          r_drop_count <= r_drop_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ats_eligibility_scheduler.sv
// tb/tb_ats_eligibility_scheduler.sv - directed bench for ats_eligibility_scheduler
module tb_ats_eligibility_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] ts_tdata;
  logic        ts_tvalid;
  logic        ts_tready;
  logic [15:0] fl_tdata;
  logic        fl_tvalid;
  logic        fl_tready;
  logic [71:0] current_time;
  logic [15:0] cfg_tpb;
  logic [15:0] cfg_burst;
  logic [71:0] cfg_maxres;
  logic        dec_tdata;
  logic        dec_tvalid;
  logic        dec_tready;
  logic [31:0] drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ats_eligibility_scheduler dut (
    .clk                        (clk),
    .rst                        (rst),
    .s_axis_timestamp_tdata     (ts_tdata),
    .s_axis_timestamp_tvalid    (ts_tvalid),
    .s_axis_timestamp_tready    (ts_tready),
    .s_axis_frame_length_tdata  (fl_tdata),
    .s_axis_frame_length_tvalid (fl_tvalid),
    .s_axis_frame_length_tready (fl_tready),
    .current_time               (current_time),
    .cfg_ticks_per_byte         (cfg_tpb),
    .cfg_burst_bytes            (cfg_burst),
    .cfg_max_residence          (cfg_maxres),
    .m_axis_decision_tdata      (dec_tdata),
    .m_axis_decision_tvalid     (dec_tvalid),
    .m_axis_decision_tready     (dec_tready),
    .drop_count                 (drop_count)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic send_frame(input logic [71:0] arr, input logic [15:0] len, output bit ok);
    ok = 1'b0;
    ts_tdata  = arr;
    fl_tdata  = len;
    ts_tvalid = 1'b1;
    fl_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ts_tready && fl_tready) begin
        step(1);
        ok = 1'b1;
        break;
      end
      step(1);
    end
    ts_tvalid = 1'b0;
    fl_tvalid = 1'b0;
  endtask

  // Returns edges elapsed after the accept edge until tvalid is seen.
  task automatic wait_valid(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (dec_tvalid) begin
        ok = 1'b1;
        break;
      end
      step(1);
      n++;
    end
  endtask

  task automatic take_decision();
    dec_tready = 1'b1;
    step(1);
    dec_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++;
    if (ts_tready !== 1'b0 || fl_tready !== 1'b0) begin
      bad++;
      $display("FAIL reset_tready: got %b/%b want 0/0", ts_tready, fl_tready);
    end
    total++;
    if (dec_tvalid !== 1'b0 || dec_tdata !== 1'b0) begin
      bad++;
      $display("FAIL reset_decision: got valid=%b data=%b want 0/0", dec_tvalid, dec_tdata);
    end
    total++;
    if (drop_count !== 32'd0 || dut.r_bucket_empty_time !== 72'd0 || dut.r_group_elig !== 72'd0) begin
      bad++;
      $display("FAIL reset_state: drop=%0d bucket=%0d group=%0d want 0/0/0",
               drop_count, dut.r_bucket_empty_time, dut.r_group_elig);
    end
    rst = 1'b0;
    step(1);
    total++;
    if (ts_tready !== 1'b1 || fl_tready !== 1'b1) begin
      bad++;
      $display("FAIL idle_tready: got %b/%b want 1/1", ts_tready, fl_tready);
    end
  endtask

  task automatic test_lone_valid();
    bit stayed = 1'b1;
    ts_tdata  = 72'd100;
    ts_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (!ts_tready || dec_tvalid) stayed = 1'b0;
    end
    ts_tvalid = 1'b0;
    total++;
    if (!stayed) begin
      bad++;
      $display("FAIL lone_tvalid: got consumed want idle");
    end
  endtask

  task automatic test_single_pass();
    bit ok;
    int n;
    cfg_tpb = 16'd8; cfg_burst = 16'd1000; cfg_maxres = 72'd10000;
    current_time = 72'd1000;
    send_frame(72'd100, 16'd64, ok);
    wait_valid(10, n, ok);
    total++;
    if (!ok || n != 3) begin
      bad++;
      $display("FAIL single_latency: got ok=%b edges=%0d want 1/3", ok, n);
    end
    total++;
    if (dec_tdata !== 1'b1) begin
      bad++;
      $display("FAIL single_pass: got %b want 1", dec_tdata);
    end
    total++;
    if (dut.r_bucket_empty_time !== 72'd512 || dut.r_group_elig !== 72'd512) begin
      bad++;
      $display("FAIL single_state: bucket=%0d group=%0d want 512/512",
               dut.r_bucket_empty_time, dut.r_group_elig);
    end
    take_decision();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit stable = 1'b1;
    int n;
    do_reset();
    cfg_tpb = 16'd8; cfg_burst = 16'd1000; cfg_maxres = 72'd10000;
    current_time = 72'd3999;
    send_frame(72'd100, 16'd500, ok);
    step(10);
    total++;
    if (dec_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b1_early: got valid=%b want 0 before time 4000", dec_tvalid);
    end
    current_time = 72'd4000;
    wait_valid(5, n, ok);
    total++;
    if (!ok || dec_tdata !== 1'b1) begin
      bad++;
      $display("FAIL b2b1_pass: got ok=%b data=%b want 1/1", ok, dec_tdata);
    end
    take_decision();
    current_time = 72'd7999;
    send_frame(72'd100, 16'd500, ok);
    step(10);
    total++;
    if (dec_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b2_early: got valid=%b want 0 before time 8000", dec_tvalid);
    end
    current_time = 72'd8000;
    wait_valid(5, n, ok);
    total++;
    if (!ok || dec_tdata !== 1'b1 || dut.r_bucket_empty_time !== 72'd8000) begin
      bad++;
      $display("FAIL b2b2_pass: got ok=%b data=%b bucket=%0d want 1/1/8000",
               ok, dec_tdata, dut.r_bucket_empty_time);
    end
    for (int i = 0; i < 20; i++) begin
      if (dec_tvalid !== 1'b1 || dec_tdata !== 1'b1 || ts_tready !== 1'b0 || fl_tready !== 1'b0)
        stable = 1'b0;
      step(1);
    end
    total++;
    if (!stable) begin
      bad++;
      $display("FAIL backpressure_hold: got unstable want valid/data held and treadys 0");
    end
    take_decision();
    total++;
    if (dec_tvalid !== 1'b0 || ts_tready !== 1'b1) begin
      bad++;
      $display("FAIL handshake_release: got valid=%b tready=%b want 0/1", dec_tvalid, ts_tready);
    end
  endtask

  task automatic test_drop();
    bit ok;
    int n;
    do_reset();
    cfg_tpb = 16'd8; cfg_burst = 16'd3000; cfg_maxres = 72'd100000;
    current_time = 72'd20000;
    send_frame(72'd0, 16'd2500, ok);
    wait_valid(10, n, ok);
    take_decision();
    total++;
    if (dut.r_bucket_empty_time !== 72'd20000) begin
      bad++;
      $display("FAIL drop_setup: bucket=%0d want 20000", dut.r_bucket_empty_time);
    end
    cfg_maxres = 72'd1000;
    current_time = 72'd0;
    send_frame(72'd100, 16'd64, ok);
    wait_valid(10, n, ok);
    total++;
    if (!ok || n != 3 || dec_tdata !== 1'b0) begin
      bad++;
      $display("FAIL drop_decision: got ok=%b edges=%0d data=%b want 1/3/0", ok, n, dec_tdata);
    end
    total++;
    if (drop_count !== 32'd1 || dut.r_bucket_empty_time !== 72'd20000 || dut.r_group_elig !== 72'd20000) begin
      bad++;
      $display("FAIL drop_state: drop=%0d bucket=%0d group=%0d want 1/20000/20000",
               drop_count, dut.r_bucket_empty_time, dut.r_group_elig);
    end
    take_decision();
  endtask

  task automatic test_long_idle();
    bit ok;
    int n;
    do_reset();
    cfg_tpb = 16'd8; cfg_burst = 16'd1000; cfg_maxres = 72'd10000;
    current_time = 72'd50000;
    send_frame(72'd50000, 16'd100, ok);
    wait_valid(10, n, ok);
    total++;
    if (!ok || dec_tdata !== 1'b1 || dut.r_bucket_empty_time !== 72'd42800 || dut.r_group_elig !== 72'd50000) begin
      bad++;
      $display("FAIL long_idle: ok=%b data=%b bucket=%0d group=%0d want 1/1/42800/50000",
               ok, dec_tdata, dut.r_bucket_empty_time, dut.r_group_elig);
    end
    take_decision();
  endtask

  task automatic test_tpb_zero();
    bit ok;
    int n;
    cfg_tpb = 16'd0;
    current_time = 72'd60000;
    send_frame(72'd60000, 16'd1000, ok);
    wait_valid(10, n, ok);
    total++;
    if (!ok || n != 3 || dec_tdata !== 1'b1 || dut.r_bucket_empty_time !== 72'd60000 || dut.r_group_elig !== 72'd60000) begin
      bad++;
      $display("FAIL tpb_zero: ok=%b edges=%0d data=%b bucket=%0d group=%0d want 1/3/1/60000/60000",
               ok, n, dec_tdata, dut.r_bucket_empty_time, dut.r_group_elig);
    end
    take_decision();
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    bit quiet = 1'b1;
    int n;
    cfg_tpb = 16'd8; cfg_maxres = 72'd100000;
    current_time = 72'd0;
    send_frame(72'd100, 16'd64, ok);
    step(6);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dec_tvalid) quiet = 1'b0;
      step(1);
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL reset_abort: got a decision want none");
    end
    current_time = 72'd1000;
    send_frame(72'd100, 16'd64, ok);
    wait_valid(10, n, ok);
    total++;
    if (!ok || n != 3 || dec_tdata !== 1'b1 || dut.r_bucket_empty_time !== 72'd512) begin
      bad++;
      $display("FAIL after_reset: ok=%b edges=%0d data=%b bucket=%0d want 1/3/1/512",
               ok, n, dec_tdata, dut.r_bucket_empty_time);
    end
    take_decision();
  endtask

  initial begin
    rst = 1'b1;
    ts_tdata = '0; ts_tvalid = 1'b0;
    fl_tdata = '0; fl_tvalid = 1'b0;
    current_time = '0;
    cfg_tpb = '0; cfg_burst = '0; cfg_maxres = '0;
    dec_tready = 1'b0;
    test_reset();
    test_lone_valid();
    test_single_pass();
    test_back_to_back();
    test_drop();
    test_long_idle();
    test_tpb_zero();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
